// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and helpers for the instruction-memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LO   = 3'd2,
    HI   = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam int BYTES_PER_WORD = 2;

  function automatic int instr_width(input int rf_bits);
    return 4 + 2 * rf_bits;
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - latches low/high bytes into a W-bit word and flags oversized high bytes
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         lo_load,
  input  logic         hi_load,
  input  logic [7:0]   data,
  output logic [W-1:0] word,
  output logic         fmt_err
);

  localparam int HI_BITS = W - 8;

  logic [7:0] lo_q;
  logic       hi_bad;

  // The high byte only carries HI_BITS meaningful bits; anything above is a framing fault.
  assign hi_bad = (data >> HI_BITS) != 8'd0;
  assign word   = {data[HI_BITS-1:0], lo_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q    <= 8'd0;
      fmt_err <= 1'b0;
    end else begin
      if (lo_load) begin
        lo_q <= data;
      end
      if (clear) begin
        fmt_err <= 1'b0;
      end else if (hi_load && hi_bad) begin
        fmt_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - frames host bytes into instruction words, writes them, releases CPU on verified load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter  int ROM_addressBits = 6,
  parameter  int RF_addressBits  = 3,
  localparam int W               = instr_width(RF_addressBits)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       imem_writeEnable,
  output logic [ROM_addressBits-1:0] imem_address,
  output logic [W-1:0]               imem_data_in,
  output logic                       cpu_rst_n,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [ROM_addressBits:0]   loaded_count
);

  state_t                     state;
  logic [ROM_addressBits-1:0] hdr;
  logic [7:0]                 csum;
  logic                       accept;
  logic                       restart;
  logic [W-1:0]               word;
  logic                       fmt_err;

  assign in_ready  = (state == HDR) || (state == LO) || (state == HI) || (state == CHK);
  assign busy      = in_ready;
  assign done      = (state == DONE);
  assign error     = (state == ERR);
  assign cpu_rst_n = (state == DONE);

  assign accept  = in_valid && in_ready;
  assign restart = start && ((state == IDLE) || (state == DONE) || (state == ERR));

  imem_word_packer #(
    .W(W)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .clear  (restart),
    .lo_load(accept && (state == LO)),
    .hi_load(accept && (state == HI)),
    .data   (in_data),
    .word   (word),
    .fmt_err(fmt_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      hdr              <= '0;
      csum             <= 8'd0;
      loaded_count     <= '0;
      imem_writeEnable <= 1'b0;
      imem_address     <= '0;
      imem_data_in     <= '0;
    end else begin
      imem_writeEnable <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= HDR;
            csum         <= 8'd0;
            loaded_count <= '0;
          end
        end
        HDR: begin
          if (accept) begin
            csum <= csum ^ in_data;
            // Header bits beyond the address range would make addresses wrap.
            if ((in_data >> ROM_addressBits) != 8'd0) begin
              state <= ERR;
            end else begin
              hdr   <= in_data[ROM_addressBits-1:0];
              state <= LO;
            end
          end
        end
        LO: begin
          if (accept) begin
            csum  <= csum ^ in_data;
            state <= HI;
          end
        end
        HI: begin
          if (accept) begin
            csum             <= csum ^ in_data;
            imem_writeEnable <= 1'b1;
            imem_address     <= loaded_count[ROM_addressBits-1:0];
            imem_data_in     <= word;
            loaded_count     <= loaded_count + 1'b1;
            state            <= (loaded_count == {1'b0, hdr}) ? CHK : LO;
          end
        end
        CHK: begin
          if (accept) begin
            state <= ((csum == in_data) && !fmt_err) ? DONE : ERR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized scoreboard bench for imem_loader
module tb_imem_loader;

  localparam int AB = 6;
  localparam int RB = 3;
  localparam int W  = 4 + 2 * RB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready;
  logic          imem_writeEnable;
  logic [AB-1:0] imem_address;
  logic [W-1:0]  imem_data_in;
  logic          cpu_rst_n;
  logic          busy;
  logic          done;
  logic          error;
  logic [AB:0]   loaded_count;

  imem_loader #(
    .ROM_addressBits(AB),
    .RF_addressBits (RB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .imem_writeEnable(imem_writeEnable),
    .imem_address    (imem_address),
    .imem_data_in    (imem_data_in),
    .cpu_rst_n       (cpu_rst_n),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .loaded_count    (loaded_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_writeEnable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", imem_address, e.addr);
        check("wr_data", imem_data_in, e.data);
        check("wr_cycle", cyc, e.cyc);
        check("wr_count", loaded_count, e.addr + 1);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit is_hi,
                           input int addr, input int data);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("handshake_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (is_hi) exp_q.push_back('{addr, data, cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Reference: word = (hi mod 2^(W-8))*256 + lo, checksum = XOR of header and payload.
  task automatic run_frame(input logic [7:0] fr[$], input int maxgap, input int stray_at);
    int         h;
    int         lo;
    int         hi;
    bit         fmt;
    bit         ok;
    logic [7:0] x;
    pulse_start();
    check("start_busy", busy, 1);
    check("start_cpu_rst_n", cpu_rst_n, 0);
    check("start_done", done, 0);
    check("start_error", error, 0);
    h = fr[0];
    send_byte(fr[0], $urandom_range(0, maxgap), 1'b0, 0, 0);
    if (h >= (1 << AB)) begin
      check("hdr_err_error", error, 1);
      check("hdr_err_in_ready", in_ready, 0);
      check("hdr_err_count", loaded_count, 0);
      check("hdr_err_cpu_rst_n", cpu_rst_n, 0);
      return;
    end
    x = fr[0];
    fmt = 1'b0;
    for (int i = 0; i <= h; i++) begin
      lo = fr[1 + 2 * i];
      hi = fr[2 + 2 * i];
      x = x ^ fr[1 + 2 * i] ^ fr[2 + 2 * i];
      if (hi >= (1 << (W - 8))) fmt = 1'b1;
      if (stray_at == 1 + 2 * i) begin
        repeat (2) @(negedge clk);
        pulse_start();
      end
      send_byte(fr[1 + 2 * i], $urandom_range(0, maxgap), 1'b0, 0, 0);
      send_byte(fr[2 + 2 * i], $urandom_range(0, maxgap), 1'b1, i,
                (hi % (1 << (W - 8))) * 256 + lo);
    end
    send_byte(fr[2 * h + 3], $urandom_range(0, maxgap), 1'b0, 0, 0);
    ok = (fr[2 * h + 3] == x) && !fmt;
    check("end_done", done, ok);
    check("end_error", error, !ok);
    check("end_cpu_rst_n", cpu_rst_n, ok);
    check("end_count", loaded_count, h + 1);
    check("end_in_ready", in_ready, 0);
    check("end_pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] fr[$];
    int         h;
    logic [7:0] x;
    int         hi;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_we", imem_writeEnable, 0);
    check("rst_count", loaded_count, 0);
    check("rst_addr", imem_address, 0);
    check("rst_data", imem_data_in, 0);
    rst = 1'b0;
    @(negedge clk);

    fr = '{8'h02, 8'h34, 8'h01, 8'hFF, 8'h03, 8'h00, 8'h02, 8'hC9};
    run_frame(fr, 0, -1);
    check("nominal_done_const", done, 1);
    check("hold_addr", imem_address, 2);
    check("hold_data", imem_data_in, 10'h200);

    fr = '{8'h02, 8'h34, 8'h01, 8'hFF, 8'h03, 8'h00, 8'h02, 8'hC8};
    run_frame(fr, 0, -1);
    check("badsum_error_const", error, 1);

    fr = '{8'h40};
    run_frame(fr, 0, -1);

    fr = '{8'h00, 8'h12, 8'h05, 8'h17};
    run_frame(fr, 0, -1);
    check("fmt_error_const", error, 1);

    fr = '{8'h02, 8'h34, 8'h01, 8'hFF, 8'h03, 8'h00, 8'h02, 8'hC9};
    run_frame(fr, 3, 3);
    check("stray_start_done", done, 1);

    pulse_start();
    send_byte(8'h02, 0, 1'b0, 0, 0);
    send_byte(8'h34, 0, 1'b0, 0, 0);
    in_valid = 1'b1;
    in_data  = 8'h01;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst_we", imem_writeEnable, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_done", done, 0);
    check("midrst_error", error, 0);
    check("midrst_cpu_rst_n", cpu_rst_n, 0);
    check("midrst_count", loaded_count, 0);
    check("midrst_data", imem_data_in, 0);
    @(negedge clk);
    check("midrst_we_later", imem_writeEnable, 0);
    fr = '{8'h02, 8'h34, 8'h01, 8'hFF, 8'h03, 8'h00, 8'h02, 8'hC9};
    run_frame(fr, 1, -1);

    for (int f = 0; f < 14; f++) begin
      h = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
      fr = {};
      fr.push_back(8'(h));
      if ($urandom_range(0, 9) == 0) fr[0] = fr[0] | 8'(1 << $urandom_range(AB, 7));
      x = fr[0];
      for (int i = 0; i <= h; i++) begin
        hi = ($urandom_range(0, 14) == 0) ? $urandom_range(4, 255) : $urandom_range(0, 3);
        fr.push_back(8'($urandom_range(0, 255)));
        fr.push_back(8'(hi));
        x = x ^ fr[fr.size() - 2] ^ fr[fr.size() - 1];
      end
      if ($urandom_range(0, 5) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
      fr.push_back(x);
      run_frame(fr, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? 1 : -1);
    end

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
